sort32_stream_ctrl: RTL and testbench

Streaming front/back-end controller for the 32-word sorting network. It collects up to 32 32-bit words over a valid/ready input stream, presents them as one 1024-bit vector to the combinational network, and waits a fixed number of cycles for the multicycle path to settle. It then captures the sorted vector and streams it out over a valid/ready output stream. The block sits between a bus-side producer/consumer and the network instance, which is external to this block.

---
 rtl/sort32_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sort32_stream_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort32_stream_ctrl.sv
// Stream controller around the external 32-word sorting network: fills net_in,
// waits NET_LAT cycles, captures net_out and drains n words. Build option: SORT_DESC_EN.
module sort32_stream_ctrl #(
    parameter int unsigned NET_LAT  = 2,
    parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic [1023:0] net_in,
    input  logic [1023:0] net_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

`ifdef SORT_DESC_EN
    localparam logic [31:0] PAD = 32'h0000_0000;
`else
    localparam logic [31:0] PAD = PAD_WORD;
`endif
    localparam logic [1023:0] PAD_VEC = {32{PAD}};
    localparam logic [3:0]    LAT_M1  = 4'(NET_LAT - 1);

    state_t         state_q, state_d;
    logic [5:0]     count_q, count_d;
    logic [3:0]     wait_q, wait_d;
    logic [4:0]     emit_q, emit_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [31:0]    out_data_q, out_data_d;
    logic [1023:0]  net_in_q, net_in_d;
    logic [1023:0]  res_q, res_d;
    logic           busy_q, busy_d;

    function automatic logic [31:0] word_at(input logic [1023:0] vec, input logic [4:0] idx);
        return vec[{idx, 5'd0} +: 32];
    endfunction

    // Slot read for the e-th emitted word: network output is always ascending.
    function automatic logic [4:0] slot_of(input logic [4:0] e);
`ifdef SORT_DESC_EN
        return 5'd31 - e;
`else
        return e;
`endif
    endfunction

    // Next-state and next-output computation for the fill / wait / drain sequence.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wait_d      = wait_q;
        emit_d      = emit_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        net_in_d    = net_in_q;
        res_d       = res_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready_q) begin
                    net_in_d[{count_q[4:0], 5'd0} +: 32] = in_data;
                    count_d = count_q + 6'd1;
                    // The 32nd word closes the frame whether or not in_last is set.
                    if (in_last || (count_q == 6'd31)) begin
                        state_d    = ST_WAIT;
                        in_ready_d = 1'b0;
                        wait_d     = 4'd0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WAIT: begin
                if (wait_q == LAT_M1) begin
                    res_d       = net_out;
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    emit_d      = 5'd0;
                    out_data_d  = word_at(net_out, slot_of(5'd0));
                    out_last_d  = (count_q == 6'd1);
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_FILL;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = 32'd0;
                        count_d     = 6'd0;
                        emit_d      = 5'd0;
                        net_in_d    = PAD_VEC;
                        in_ready_d  = 1'b1;
                    end else begin
                        emit_d     = emit_q + 5'd1;
                        out_data_d = word_at(res_q, slot_of(emit_q + 5'd1));
                        out_last_d = (({1'b0, emit_q} + 6'd2) == count_q);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_FILL;
                count_d     = 6'd0;
                wait_d      = 4'd0;
                emit_d      = 5'd0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = 32'd0;
                net_in_d    = PAD_VEC;
            end
        endcase
        busy_d = !((state_d == ST_FILL) && (count_d == 6'd0));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            count_q     <= 6'd0;
            wait_q      <= 4'd0;
            emit_q      <= 5'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 32'd0;
            net_in_q    <= PAD_VEC;
            res_q       <= PAD_VEC;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            emit_q      <= emit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            net_in_q    <= net_in_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign net_in    = net_in_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sort32_stream_ctrl.sv
// Self-checking bench for sort32_stream_ctrl with a behavioural sorting network
// that only presents a valid result after NET_LAT stable cycles.
module tb_sort32_stream_ctrl;
    localparam int NET_LAT = 2;
`ifdef SORT_DESC_EN
    localparam logic [31:0] PAD = 32'h0000_0000;
`else
    localparam logic [31:0] PAD = 32'hFFFF_FFFF;
`endif

    typedef logic [31:0] wq_t[$];
    typedef bit bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'd0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic          out_last;
    logic [1023:0] net_in;
    logic [1023:0] net_out;
    logic          busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [1023:0] seen_in;
    int stable = 0;

    sort32_stream_ctrl #(.NET_LAT(NET_LAT), .PAD_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .net_in(net_in), .net_out(net_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1023:0] sort_vec(input logic [1023:0] v);
        logic [31:0] q[$];
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) q.push_back(v[i*32 +: 32]);
        q.sort();
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = q[i];
        return r;
    endfunction

    // Network model: output is garbage until net_in has been stable NET_LAT cycles.
    always @(negedge clk) begin
        if (net_in !== seen_in) begin
            seen_in = net_in;
            stable = 1;
        end else if (stable < 100) begin
            stable = stable + 1;
        end
        net_out = (stable >= NET_LAT) ? sort_vec(net_in) : ~sort_vec(net_in);
    end

    function automatic wq_t ref_out(input wq_t w);
        wq_t r;
        r = w;
`ifdef SORT_DESC_EN
        r.rsort();
`else
        r.sort();
`endif
        return r;
    endfunction

    task automatic send_frame(input wq_t w, input bit close, input bit gaps, output int acc_cyc);
        acc_cyc = -1;
        for (int i = 0; i < w.size(); i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = close && (i == w.size() - 1);
            for (int g = 0; g < 200 && !in_ready; g++) @(negedge clk);
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL send_timeout idx=%0d in_ready=%b want=1", i, in_ready);
            end
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int mode, output wq_t gd, output bq_t gl, output int first_cyc,
                           output int last_cyc, output int stall_bad, output int ready_bad);
        logic [31:0] hd;
        logic hl;
        bit held, done;
        int k;
        held = 0; done = 0; k = 0; hd = 32'd0; hl = 1'b0;
        gd = {}; gl = {};
        first_cyc = -1; last_cyc = -1; stall_bad = 0; ready_bad = 0;
        for (int g = 0; g < 400 && !done; g++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ((k % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (in_ready) ready_bad++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held && (out_data !== hd || out_last !== hl)) stall_bad++;
                k++;
                if (out_ready) begin
                    gd.push_back(out_data);
                    gl.push_back(out_last);
                    held = 0;
                    last_cyc = cyc;
                    if (out_last || gd.size() >= 40) done = 1;
                end else begin
                    held = 1; hd = out_data; hl = out_last;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (!done) begin
            total++; bad++;
            $display("FAIL collect_timeout words=%0d want_last_seen=1", gd.size());
        end
    endtask

    task automatic test_reset;
        logic [1023:0] pv;
        pv = {32{PAD}};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (net_in !== pv) begin bad++; $display("FAIL reset_net_in slot0=%h want=%h", net_in[31:0], PAD); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame;
        wq_t w, exp, gd; bq_t gl;
        int acc, fc, lc, sb, rb;
        for (int i = 31; i >= 0; i--) w.push_back(32'(i));
        send_frame(w, 1'b1, 1'b0, acc);
        collect(0, gd, gl, fc, lc, sb, rb);
        exp = ref_out(w);
        total++; if (gd.size() != exp.size()) begin bad++; $display("FAIL full_count got=%0d want=%0d", gd.size(), exp.size()); end
        for (int i = 0; i < gd.size() && i < exp.size(); i++) begin
            total++;
            if (gd[i] !== exp[i] || gl[i] !== (i == exp.size() - 1)) begin
                bad++; $display("FAIL full_word[%0d] got=%h/%b want=%h/%b", i, gd[i], gl[i], exp[i], (i == exp.size() - 1));
            end
        end
        total++; if (fc != acc + NET_LAT + 1) begin bad++; $display("FAIL full_latency got=%0d want=%0d", fc - acc, NET_LAT + 1); end
        total++; if (lc != fc + 31) begin bad++; $display("FAIL full_consecutive got=%0d want=%0d", lc - fc, 31); end
        total++; if (rb != 0) begin bad++; $display("FAIL full_in_ready_during got=%0d want=0", rb); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL full_after rdy=%b vld=%b busy=%b want=1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_frame(input string name, input wq_t w, input bit close, input int mode);
        wq_t exp, gd; bq_t gl;
        int acc, fc, lc, sb, rb;
        send_frame(w, close, mode == 2, acc);
        collect(mode, gd, gl, fc, lc, sb, rb);
        exp = ref_out(w);
        total++; if (gd.size() != exp.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, gd.size(), exp.size()); end
        for (int i = 0; i < gd.size() && i < exp.size(); i++) begin
            total++;
            if (gd[i] !== exp[i] || gl[i] !== (i == exp.size() - 1)) begin
                bad++; $display("FAIL %s_word[%0d] got=%h/%b want=%h/%b", name, i, gd[i], gl[i], exp[i], (i == exp.size() - 1));
            end
        end
        total++; if (fc != acc + NET_LAT + 1) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, fc - acc, NET_LAT + 1); end
        total++; if (sb != 0) begin bad++; $display("FAIL %s_stall_hold got=%0d want=0", name, sb); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL %s_after rdy=%b vld=%b want=1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_short;
        test_frame("short", '{32'd7, 32'd3, 32'd9}, 1'b1, 0);
    endtask

    task automatic test_backpressure;
        test_frame("bp", '{32'd5, 32'd5, 32'd1}, 1'b1, 1);
    endtask

    task automatic test_pad_collision;
        test_frame("pad", '{32'hFFFF_FFFF, 32'h0}, 1'b1, 0);
        test_frame("one", '{32'd42}, 1'b1, 0);
    endtask

    task automatic test_overrun;
        wq_t w, exp, gd; bq_t gl;
        int acc, fc, lc, sb, rb;
        logic [31:0] extra;
        for (int i = 0; i < 32; i++) w.push_back($urandom);
        extra = $urandom;
        send_frame(w, 1'b0, 1'b0, acc);
        in_valid = 1'b1; in_data = extra; in_last = 1'b1;
        collect(0, gd, gl, fc, lc, sb, rb);
        exp = ref_out(w);
        total++; if (gd.size() != 32) begin bad++; $display("FAIL ovr_count got=%0d want=32", gd.size()); end
        for (int i = 0; i < gd.size() && i < 32; i++) begin
            total++;
            if (gd[i] !== exp[i] || gl[i] !== (i == 31)) begin
                bad++; $display("FAIL ovr_word[%0d] got=%h/%b want=%h/%b", i, gd[i], gl[i], exp[i], (i == 31));
            end
        end
        total++; if (rb != 0) begin bad++; $display("FAIL ovr_no_accept got=%0d want=0", rb); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ovr_ready_after got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        collect(0, gd, gl, fc, lc, sb, rb);
        total++; if (gd.size() != 1 || gd[0] !== extra || gl[0] !== 1'b1) begin
            bad++; $display("FAIL ovr_33rd count=%0d got=%h want=%h", gd.size(), (gd.size() > 0) ? gd[0] : 32'hX, extra);
        end
    endtask

    task automatic test_reset_in_wait;
        int acc, vcnt;
        send_frame('{32'd9, 32'd2, 32'd6}, 1'b1, 1'b0, acc);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rw_wait busy=%b rdy=%b want=1/0", busy, in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rw_reset rdy=%b vld=%b busy=%b want=1/0/0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        total++; if (vcnt != 0) begin bad++; $display("FAIL rw_no_output got=%0d want=0", vcnt); end
        test_frame("rw_next", '{32'd3, 32'd1, 32'd2}, 1'b1, 0);
    endtask

    task automatic test_random;
        wq_t w;
        int len;
        bit close;
        for (int f = 0; f < 10; f++) begin
            w = {};
            len = $urandom_range(1, 32);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: w.push_back(32'($urandom_range(0, 7)));
                    1: w.push_back(PAD);
                    default: w.push_back($urandom);
                endcase
            end
            close = (len < 32) ? 1'b1 : 1'($urandom_range(0, 1));
            test_frame("rand", w, close, $urandom_range(0, 2));
        end
    endtask

`ifdef SORT_DESC_EN
    task automatic test_desc;
        wq_t gd; bq_t gl;
        int acc, fc, lc, sb, rb;
        send_frame('{32'd1, 32'd4, 32'd2}, 1'b1, 1'b0, acc);
        collect(0, gd, gl, fc, lc, sb, rb);
        total++;
        if (gd.size() != 3 || gd[0] !== 32'd4 || gd[1] !== 32'd2 || gd[2] !== 32'd1 || gl[2] !== 1'b1 || gl[0] !== 1'b0) begin
            bad++; $display("FAIL desc_order count=%0d want=3 words 4,2,1 last on 1", gd.size());
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_short();
        test_overrun();
        test_backpressure();
        test_pad_collision();
        test_reset_in_wait();
`ifdef SORT_DESC_EN
        test_desc();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
